// File: rtl/dma_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : dma_cmd_queue
// Purpose  : Descriptor FIFO that issues DMA transfers one at a time, with a
//            watchdog timeout and completion pulses.
// Revision : 1.0
// ============================================================================
module dma_cmd_queue #(
  parameter int ADDR_W  = 65,
  parameter int LEN_W   = 64,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_W-1:0]          cmd_ram_addr,
  input  logic [ADDR_W-1:0]          cmd_disk_addr,
  input  logic [LEN_W-1:0]           cmd_amount,
  input  logic                       cmd_dir,
  output logic [ADDR_W-1:0]          RAM_address,
  output logic [ADDR_W-1:0]          Disk_address,
  output logic [LEN_W-1:0]           amount,
  output logic                       read,
  output logic                       write,
  output logic                       start,
  input  logic                       finish,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       done_pulse,
  output logic                       timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 2 * ADDR_W + LEN_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     wd_cnt;
  logic              armed;

  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] head_ram;
  logic [ADDR_W-1:0] head_disk;
  logic [LEN_W-1:0]  head_amt;
  logic              head_dir;

  assign cmd_ready   = (count < CW'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == S_IDLE) && (count != '0);
  assign head        = mem[rd_ptr];
  assign head_ram    = head[ADDR_W-1:0];
  assign head_disk   = head[2*ADDR_W-1:ADDR_W];
  assign head_amt    = head[2*ADDR_W+LEN_W-1:2*ADDR_W];
  assign head_dir    = head[EW-1];
  assign queue_count = count;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_dir, cmd_amount, cmd_disk_addr, cmd_ram_addr};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      RAM_address  <= '0;
      Disk_address <= '0;
      amount       <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      start        <= 1'b0;
      done_pulse   <= 1'b0;
      timeout_err  <= 1'b0;
      wd_cnt       <= '0;
      armed        <= 1'b0;
    end else begin
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            RAM_address  <= head_ram;
            Disk_address <= head_disk;
            amount       <= head_amt;
            if (head_amt == '0) begin
              // Zero-length transfers complete without ever touching the DMA
              done_pulse <= 1'b1;
              state      <= S_DONE;
            end else begin
              read  <= ~head_dir;
              write <= head_dir;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          start  <= 1'b1;
          wd_cnt <= '0;
          armed  <= 1'b0;
          state  <= S_RUN;
        end
        S_RUN: begin
          // A finish still high from the previous job must drop before it counts
          if (!finish) armed <= 1'b1;
          wd_cnt <= wd_cnt + 1'b1;
          if (finish && armed) begin
            start      <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            done_pulse <= 1'b1;
            state      <= S_DONE;
          end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
            start       <= 1'b0;
            read        <= 1'b0;
            write       <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_cmd_queue
// Purpose  : Scoreboard bench for dma_cmd_queue with a responsive DMA model.
// Revision : 1.0
// ============================================================================
module tb_dma_cmd_queue;

  localparam int ADDR_W  = 65;
  localparam int LEN_W   = 64;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_ram_addr;
  logic [ADDR_W-1:0] cmd_disk_addr;
  logic [LEN_W-1:0]  cmd_amount;
  logic              cmd_dir;
  logic [ADDR_W-1:0] RAM_address;
  logic [ADDR_W-1:0] Disk_address;
  logic [LEN_W-1:0]  amount;
  logic              read;
  logic              write;
  logic              start;
  logic              finish;
  logic              busy;
  logic [CW-1:0]     queue_count;
  logic              done_pulse;
  logic              timeout_err;

  dma_cmd_queue #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ram_addr(cmd_ram_addr), .cmd_disk_addr(cmd_disk_addr),
    .cmd_amount(cmd_amount), .cmd_dir(cmd_dir),
    .RAM_address(RAM_address), .Disk_address(Disk_address),
    .amount(amount), .read(read), .write(write), .start(start),
    .finish(finish), .busy(busy), .queue_count(queue_count),
    .done_pulse(done_pulse), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] ram;
    logic [ADDR_W-1:0] disk;
    logic [LEN_W-1:0]  amt;
    logic              dir;
  } desc_t;

  desc_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // The DMA model never answers descriptors whose low nibble is all ones.
  function automatic bit never_answered(input logic [LEN_W-1:0] a);
    return (a != '0) && (a[3:0] == 4'hF);
  endfunction

  // DMA model: finish after amount[2:0]+1 cycles, hold until start drops,
  // then sometimes keep it high a while so it is stale for the next job.
  int               rp = 0;
  int               lat = 0;
  int               stale = 0;
  logic [LEN_W-1:0] seen_amt;
  initial begin
    finish = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        rp = 0; finish = 1'b0;
      end else begin
        case (rp)
          0: if (start) begin
               seen_amt = amount;
               if (never_answered(seen_amt)) rp = 4;
               else begin lat = int'(seen_amt[2:0]) + 1; finish = 1'b0; rp = 1; end
             end
          1: begin
               finish = 1'b0;
               lat--;
               if (lat == 0) begin finish = 1'b1; rp = 2; end
             end
          2: if (!start) begin
               stale = $urandom_range(0, 6);
               if (stale == 0) begin finish = 1'b0; rp = 0; end
               else rp = 3;
             end
          3: begin
               stale--;
               if (stale == 0) begin finish = 1'b0; rp = 0; end
             end
          default: begin
               finish = 1'b0;
               if (!start) rp = 0;
             end
        endcase
      end
    end
  end

  // Monitor: checks issue order, direction, completion kind and timing
  logic prev_start = 1'b0;
  bit   cur_started = 0;
  bit   saw_zero = 0;
  int   run_len = 0;
  initial begin
    desc_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_start = 1'b0; cur_started = 0; saw_zero = 0; run_len = 0;
      end else begin
        if (read && write) chk("rw_exclusive", {read, write}, 2'b00);
        if (start) begin
          if (!prev_start) begin
            if (exp_q.size() == 0) chk("issue_without_cmd", 1, 0);
            else begin
              e = exp_q[0];
              chk("issue_ram", RAM_address, e.ram);
              chk("issue_disk", Disk_address, e.disk);
              chk("issue_amt", amount, e.amt);
              chk("issue_dir", {read, write}, {~e.dir, e.dir});
            end
            cur_started = 1; run_len = 0; saw_zero = 0;
          end
          run_len++;
          if (!finish) saw_zero = 1;
        end
        if (done_pulse || timeout_err) begin
          if (exp_q.size() == 0) chk("pulse_without_cmd", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {done_pulse, timeout_err},
                never_answered(e.amt) ? 2'b01 : 2'b10);
            chk("started", cur_started, e.amt != '0);
            chk("done_outputs", {start, read, write}, 3'b000);
            chk("held_ram", RAM_address, e.ram);
            chk("held_amt", amount, e.amt);
            if (never_answered(e.amt)) chk("timeout_len", run_len, TIMEOUT);
            else if (e.amt != '0) chk("armed_before_done", saw_zero, 1);
          end
          cur_started = 0; saw_zero = 0; run_len = 0;
        end
        prev_start = start;
      end
    end
  end

  // Must be called just after a negedge; returns just after the next negedge.
  task automatic push(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] d,
                      input logic [LEN_W-1:0] a, input logic dr);
    int n = 0;
    desc_t e;
    cmd_valid = 1'b1; cmd_ram_addr = r; cmd_disk_addr = d; cmd_amount = a; cmd_dir = dr;
    while (!cmd_ready && n < 200) begin @(negedge clock); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL push_wait: cmd_ready stuck at 0 for %0d cycles", n);
    end else begin
      e.ram = r; e.disk = d; e.amt = a; e.dir = dr;
      exp_q.push_back(e);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || queue_count != '0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clock); n++;
    end
    if (busy || queue_count != '0 || exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: busy=%0d count=%0d pending=%0d required 0 0 0",
               busy, queue_count, exp_q.size());
    end
  endtask

  task automatic push_rand();
    logic [LEN_W-1:0] a;
    int r;
    a = {$urandom, $urandom};
    r = $urandom_range(0, 7);
    if (r == 0) a = '0;
    else if (r == 1) a[3:0] = 4'hF;
    else if (a[3:0] == 4'hF || a == '0) a[3:0] = 4'h1;
    push({1'($urandom), $urandom, $urandom}, {1'($urandom), $urandom, $urandom},
         a, 1'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_ram_addr = '0; cmd_disk_addr = '0; cmd_amount = '0; cmd_dir = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {start, read, write, busy, done_pulse, timeout_err}, 6'b0);
    chk("rst_count", queue_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_addr", RAM_address, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single write descriptor with exact LOAD/RUN timing
    push(65'd100, 65'd200, 64'd5, 1'b1);
    @(negedge clock);
    chk("load_ctrl", {busy, start, read, write}, 4'b1001);
    @(negedge clock);
    chk("run_ctrl", {start, read, write}, 3'b101);
    wait_idle();

    // Zero-length descriptor completes two cycles after being offered
    push(65'd7, 65'd8, 64'd0, 1'b0);
    @(negedge clock);
    chk("zero_done", {done_pulse, start}, 2'b10);
    push(65'd9, 65'd10, 64'd3, 1'b0);
    wait_idle();

    // Fill while a never-answered job runs; extra valids while full are dropped
    push(65'd1, 65'd2, 64'h2F, 1'b1);
    push(65'd3, 65'd4, 64'd6, 1'b0);
    push(65'd5, 65'd6, 64'd0, 1'b1);
    push(65'd11, 65'd12, 64'd9, 1'b1);
    push(65'd13, 65'd14, 64'd2, 1'b0);
    chk("full_count", queue_count, DEPTH);
    chk("full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_ram_addr = 65'h1DEAD; cmd_amount = 64'd1;
    repeat (3) begin
      @(negedge clock);
      chk("full_ready_hold", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    chk("full_count_hold", queue_count, DEPTH);
    wait_idle();

    // Randomised traffic with idle gaps
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      push_rand();
    end
    wait_idle();

    // Reset while running with two descriptors queued
    push(65'd21, 65'd22, 64'h1F, 1'b0);
    push(65'd23, 65'd24, 64'd4, 1'b1);
    push(65'd25, 65'd26, 64'd4, 1'b0);
    n = 0;
    while (!(start && queue_count == 2) && n < 50) begin @(negedge clock); n++; end
    chk("pre_reset_state", {start, queue_count}, {1'b1, CW'(2)});
    reset = 1'b1;
    @(negedge clock);
    chk("mid_reset_ctrl", {start, read, write, busy, done_pulse, timeout_err}, 6'b0);
    chk("mid_reset_count", queue_count, 0);
    exp_q.delete();
    @(negedge clock);
    chk("mid_reset_nopulse", {done_pulse, timeout_err}, 2'b00);
    reset = 1'b0;
    @(negedge clock);
    push(65'd31, 65'd32, 64'd3, 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
